// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Mode encoding and reserved-mode detection.
package shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_e;

  // Any code outside the enum is reserved.
  function automatic logic mode_reserved(
    input logic [MODE_W-1:0] m
  );
    logic r;
    case (shift_mode_e'(m))
      SLL, SRL, SRA, ROL, ROR: r = 1'b0;
      default:                 r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional shift by STEP, then register bank.
// Ports: en (advance), *_d (stage inputs), *_q (registered outputs).
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH),
  localparam int K    = $clog2(STEP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              valid_d,
  input  logic [WIDTH-1:0]  data_d,
  input  logic [SHW-1:0]    amt_d,
  input  logic [MODE_W-1:0] mode_d,
  input  logic              sign_d,
  input  logic [TAG_W-1:0]  tag_d,
  input  logic              err_d,
  output logic              valid_q,
  output logic [WIDTH-1:0]  data_q,
  output logic [SHW-1:0]    amt_q,
  output logic [MODE_W-1:0] mode_q,
  output logic              sign_q,
  output logic [TAG_W-1:0]  tag_q,
  output logic              err_q
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_d;
    if (amt_d[K] && !err_d) begin
      case (shift_mode_e'(mode_d))
        SLL: shifted = {data_d[WIDTH-1-STEP:0],
                        {STEP{1'b0}}};
        SRL: shifted = {{STEP{1'b0}},
                        data_d[WIDTH-1:STEP]};
        // Fill uses the sign captured at accept,
        // not the current MSB.
        SRA: shifted = {{STEP{sign_d}},
                        data_d[WIDTH-1:STEP]};
        ROL: shifted = {data_d[WIDTH-1-STEP:0],
                        data_d[WIDTH-1:WIDTH-STEP]};
        ROR: shifted = {data_d[STEP-1:0],
                        data_d[WIDTH-1:STEP]};
        default: shifted = data_d;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= shifted;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator, one stage per amount bit.
// Ports: in_* valid/ready operand side, out_* valid/ready result side.
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_amt,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_zero,
  output logic              out_err
);

  logic              valid [SHW+1];
  logic [WIDTH-1:0]  data  [SHW+1];
  logic [SHW-1:0]    amt   [SHW+1];
  logic [MODE_W-1:0] mode  [SHW+1];
  logic              sign  [SHW+1];
  logic [TAG_W-1:0]  tag   [SHW+1];
  logic              err   [SHW+1];
  logic              stall;
  logic              unused;

  // Whole pipe freezes while the head is blocked.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign valid[0] = in_valid;
  assign data[0]  = in_data;
  assign amt[0]   = in_amt;
  assign mode[0]  = in_mode;
  assign sign[0]  = in_data[WIDTH-1];
  assign tag[0]   = in_tag;
  assign err[0]   = mode_reserved(in_mode);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STEP  (1 << k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (~stall),
      .valid_d (valid[k]),
      .data_d  (data[k]),
      .amt_d   (amt[k]),
      .mode_d  (mode[k]),
      .sign_d  (sign[k]),
      .tag_d   (tag[k]),
      .err_d   (err[k]),
      .valid_q (valid[k+1]),
      .data_q  (data[k+1]),
      .amt_q   (amt[k+1]),
      .mode_q  (mode[k+1]),
      .sign_q  (sign[k+1]),
      .tag_q   (tag[k+1]),
      .err_q   (err[k+1])
    );
  end

  assign out_valid = valid[SHW];
  assign out_data  = data[SHW];
  assign out_tag   = tag[SHW];
  assign out_err   = err[SHW];
  assign out_zero  = (data[SHW] == '0);

  // Last-stage control fields have no consumer.
  assign unused = &{1'b0, amt[SHW], mode[SHW], sign[SHW]};

endmodule
